// File: rtl/pe_conv_seq.sv
// Convolution loop sequencer: one weight/activation/psum address beat per (tile, oy, ox, ky, kx).
// Latency: start -> CHECK (1 cycle) -> first beat valid; done rises PIPE_DRAIN cycles after the last accepted beat.
// Backpressure: valid/ready; every beat field is registered and held stable while out_ready is low.
//
// Ports: clk/rst_n (synchronous active-low reset); cfg_we/cfg_addr/cfg_wdata/cfg_rdata register port
// (0 ctrl, 1 status, 2 kernel, 3 input dims, 4 stride/pad, 5 output dims, 6 COUT);
// out_valid/out_ready beat handshake carrying wbuf_addr, abuf_addr, pad_zero, psum_addr,
// acc_first, acc_last and tile_idx; busy while checking, running or draining.
// Optional macro PE_SEQ_PERF_EN adds busy-cycle (reg 7) and stall-cycle (reg 8) counters.
module pe_conv_seq #(
    parameter int COUT_LANES  = 16,
    parameter int ADDR_W      = 16,
    parameter int PSUM_ADDR_W = 10,
    parameter int MAX_COUT    = 64,
    parameter int PIPE_DRAIN  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    output logic [31:0]            cfg_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      wbuf_addr,
    output logic [ADDR_W-1:0]      abuf_addr,
    output logic                   pad_zero,
    output logic [PSUM_ADDR_W-1:0] psum_addr,
    output logic                   acc_first,
    output logic                   acc_last,
    output logic [7:0]             tile_idx,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DRAIN} state_t;
    state_t state;

    logic [3:0] kh, kw, stride, pad;
    logic [7:0] in_h, in_w, out_h, out_w, cout;
    logic       done, start_ignored, cfg_err, aborted;
    logic [7:0] nt, drain_cnt;
    logic [7:0] oy, ox;
    logic [3:0] ky, kx;

    logic ctrl_wr, start_req, abort_req, accept, cfg_bad, is_last, load;
    logic [7:0] nt_calc;
    logic [7:0] n_tile, n_oy, n_ox;
    logic [3:0] n_ky, n_kx;
    logic [16:0] iy, ix;
    logic        outside;
    logic [31:0] a_lin, w_lin, p_lin;
    logic        unused_wdata;

    assign unused_wdata = ^cfg_wdata[31:16];

    assign ctrl_wr   = cfg_we && (cfg_addr == 4'd0);
    assign abort_req = ctrl_wr && cfg_wdata[1];
    // abort in the same write suppresses start
    assign start_req = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
    assign accept    = out_valid && out_ready;
    assign nt_calc   = 8'((32'(cout) + 32'(COUT_LANES) - 32'd1) / 32'(COUT_LANES));
    assign cfg_bad   = (kh == 4'd0) || (kw == 4'd0) || (stride == 4'd0) || (out_h == 8'd0) ||
                       (out_w == 8'd0) || (cout == 8'd0) || (32'(cout) > 32'(MAX_COUT));
    assign is_last   = (tile_idx == nt - 8'd1) && (oy == out_h - 8'd1) && (ox == out_w - 8'd1) &&
                       (ky == kh - 4'd1) && (kx == kw - 4'd1);
    assign load      = !abort_req && (((state == CHECK) && !cfg_bad) ||
                                      ((state == RUN) && accept && !is_last));

    // Loop indices of the beat that will be loaded next: all zero when leaving CHECK,
    // otherwise the current indices advanced kx-first.
    always_comb begin
        n_tile = tile_idx;
        n_oy   = oy;
        n_ox   = ox;
        n_ky   = ky;
        n_kx   = kx;
        if (state == CHECK) begin
            n_tile = 8'd0;
            n_oy   = 8'd0;
            n_ox   = 8'd0;
            n_ky   = 4'd0;
            n_kx   = 4'd0;
        end else if (kx != kw - 4'd1) begin
            n_kx = kx + 4'd1;
        end else begin
            n_kx = 4'd0;
            if (ky != kh - 4'd1) begin
                n_ky = ky + 4'd1;
            end else begin
                n_ky = 4'd0;
                if (ox != out_w - 8'd1) begin
                    n_ox = ox + 8'd1;
                end else begin
                    n_ox = 8'd0;
                    if (oy != out_h - 8'd1) begin
                        n_oy = oy + 8'd1;
                    end else begin
                        n_oy   = 8'd0;
                        n_tile = tile_idx + 8'd1;
                    end
                end
            end
        end
    end

    // Beat arithmetic on the next indices. iy/ix wrap modulo 2^17, so bit 16 is the sign.
    // nt is only latched in CHECK, but the first beat has tap 0 and tile 0 so it never needs it.
    always_comb begin
        iy      = 17'(n_oy) * 17'(stride) + 17'(n_ky) - 17'(pad);
        ix      = 17'(n_ox) * 17'(stride) + 17'(n_kx) - 17'(pad);
        outside = iy[16] || ix[16] || (iy[15:0] >= 16'(in_h)) || (ix[15:0] >= 16'(in_w));
        a_lin   = 32'(iy[15:0]) * 32'(in_w) + 32'(ix[15:0]);
        w_lin   = (32'(n_ky) * 32'(kw) + 32'(n_kx)) * (32'(nt) * 32'(COUT_LANES)) +
                  32'(n_tile) * 32'(COUT_LANES);
        p_lin   = 32'(n_tile) * 32'(out_h) * 32'(out_w) + 32'(n_oy) * 32'(out_w) + 32'(n_ox);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            kh            <= '0;
            kw            <= '0;
            stride        <= '0;
            pad           <= '0;
            in_h          <= '0;
            in_w          <= '0;
            out_h         <= '0;
            out_w         <= '0;
            cout          <= '0;
            done          <= 1'b0;
            start_ignored <= 1'b0;
            cfg_err       <= 1'b0;
            aborted       <= 1'b0;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            nt            <= '0;
            drain_cnt     <= '0;
            tile_idx      <= '0;
            oy            <= '0;
            ox            <= '0;
            ky            <= '0;
            kx            <= '0;
            wbuf_addr     <= '0;
            abuf_addr     <= '0;
            pad_zero      <= 1'b0;
            psum_addr     <= '0;
            acc_first     <= 1'b0;
            acc_last      <= 1'b0;
        end else begin
            // geometry is frozen for the whole run
            if (cfg_we && (state == IDLE)) begin
                case (cfg_addr)
                    4'd2: begin kh <= cfg_wdata[11:8]; kw <= cfg_wdata[3:0]; end
                    4'd3: begin in_h <= cfg_wdata[15:8]; in_w <= cfg_wdata[7:0]; end
                    4'd4: begin pad <= cfg_wdata[7:4]; stride <= cfg_wdata[3:0]; end
                    4'd5: begin out_h <= cfg_wdata[15:8]; out_w <= cfg_wdata[7:0]; end
                    4'd6: cout <= cfg_wdata[7:0];
                    default: ;
                endcase
            end

            if ((state != IDLE) && abort_req) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                aborted   <= 1'b1;
            end else begin
                if ((state != IDLE) && start_req) start_ignored <= 1'b1;
                case (state)
                    IDLE: if (start_req) begin
                        done          <= 1'b0;
                        start_ignored <= 1'b0;
                        cfg_err       <= 1'b0;
                        aborted       <= 1'b0;
                        busy          <= 1'b1;
                        state         <= CHECK;
                    end
                    CHECK: if (cfg_bad) begin
                        cfg_err <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        nt        <= nt_calc;
                        out_valid <= 1'b1;
                        state     <= RUN;
                    end
                    RUN: if (accept && is_last) begin
                        out_valid <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                    DRAIN: if (drain_cnt == 8'(PIPE_DRAIN - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (load) begin
                tile_idx  <= n_tile;
                oy        <= n_oy;
                ox        <= n_ox;
                ky        <= n_ky;
                kx        <= n_kx;
                wbuf_addr <= ADDR_W'(w_lin);
                abuf_addr <= outside ? '0 : ADDR_W'(a_lin);
                pad_zero  <= outside;
                psum_addr <= PSUM_ADDR_W'(p_lin);
                acc_first <= (n_ky == 4'd0) && (n_kx == 4'd0);
                acc_last  <= (n_ky == kh - 4'd1) && (n_kx == kw - 4'd1);
            end
        end
    end

`ifdef PE_SEQ_PERF_EN
    logic [31:0] busy_cycles, stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_cycles  <= '0;
            stall_cycles <= '0;
        end else if ((state == IDLE) && start_req) begin
            busy_cycles  <= '0;
            stall_cycles <= '0;
        end else begin
            if (busy && (busy_cycles != '1)) busy_cycles <= busy_cycles + 32'd1;
            if (out_valid && !out_ready && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            4'd1: cfg_rdata = {27'd0, aborted, cfg_err, start_ignored, busy, done};
            4'd2: cfg_rdata = {20'd0, kh, 4'd0, kw};
            4'd3: cfg_rdata = {16'd0, in_h, in_w};
            4'd4: cfg_rdata = {24'd0, pad, stride};
            4'd5: cfg_rdata = {16'd0, out_h, out_w};
            4'd6: cfg_rdata = {24'd0, cout};
`ifdef PE_SEQ_PERF_EN
            4'd7: cfg_rdata = busy_cycles;
            4'd8: cfg_rdata = stall_cycles;
`endif
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pe_conv_seq.sv
module tb_pe_conv_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        out_valid, out_ready;
    logic [15:0] wbuf_addr, abuf_addr;
    logic        pad_zero, acc_first, acc_last, busy;
    logic [9:0]  psum_addr;
    logic [7:0]  tile_idx;

    always #5 clk = ~clk;

    pe_conv_seq dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .wbuf_addr(wbuf_addr), .abuf_addr(abuf_addr),
        .pad_zero(pad_zero), .psum_addr(psum_addr), .acc_first(acc_first),
        .acc_last(acc_last), .tile_idx(tile_idx), .busy(busy)
    );

    typedef struct packed {
        logic [15:0] wbuf;
        logic [15:0] abuf;
        logic [9:0]  psum;
        logic        pad;
        logic        first;
        logic        last;
        logic [7:0]  tile;
    } beat_t;

    beat_t bq[$];
    int    errors = 0;
    int    checks = 0;
    int    beats, acc_cyc, done_cyc;
    logic  stable;
    logic  saw_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t cur();
        return {wbuf_addr, abuf_addr, psum_addr, pad_zero, acc_first, acc_last, tile_idx};
    endfunction

    function automatic beat_t at(input int i);
        if (i < bq.size()) return bq[i];
        return '0;
    endfunction

    // inputs change 1 time unit after the edge; outputs are sampled 2 units after it
    task automatic step();
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        cfg_addr  = 4'd1;
        cfg_wdata = '0;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
    endtask

    task automatic geometry(input int k_h, input int k_w, input int i_h, input int i_w,
                            input int s, input int p, input int o_h, input int o_w, input int co);
        wr(4'd2, 32'((k_h << 8) | k_w));
        wr(4'd3, 32'((i_h << 8) | i_w));
        wr(4'd4, 32'((p << 4) | s));
        wr(4'd5, 32'((o_h << 8) | o_w));
        wr(4'd6, 32'(co));
    endtask

    // act: 0 none, 1 start during run, 2 abort, 3 reset, 4 hold out_ready low 5 cycles
    task automatic run(input int budget, input int act_beat, input int act);
        int    stall_left;
        bit    fired;
        beat_t held;
        beats = 0; acc_cyc = -1; done_cyc = -1; stable = 1'b1;
        fired = 0; stall_left = 0; held = '0;
        bq.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            out_ready = 1'b1;
            if (cfg_rdata[0]) begin
                done_cyc = cyc;
                break;
            end
            if (!fired && act != 0 && out_valid && beats == act_beat) begin
                fired = 1;
                case (act)
                    1: begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'd1; end
                    2: begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'd2; out_ready = 1'b0; end
                    3: begin rst_n = 1'b0; out_ready = 1'b0; end
                    default: begin stall_left = 5; held = cur(); end
                endcase
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                if (cur() !== held || !out_valid) stable = 1'b0;
                stall_left--;
            end
            if (out_valid && out_ready) begin
                bq.push_back(cur());
                beats++;
                acc_cyc = cyc + 1;
            end
            step();
            if (fired && (act == 2 || act == 3)) break;
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd1; cfg_wdata = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_ctl", 32'({out_valid, pad_zero, acc_first, acc_last, busy, tile_idx, psum_addr}), 32'd0);
        chk("rst_addr", {wbuf_addr, abuf_addr}, 32'd0);
        chk("rst_status", cfg_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // baseline: 3x3, 8x8, stride 1, pad 1, COUT 10 -> one tile, 576 beats
        geometry(3, 3, 8, 8, 1, 1, 8, 8, 10);
        cfg_addr = 4'd2; #1;
        chk("reg_kernel", cfg_rdata, 32'h303);
        cfg_addr = 4'd1; #1;
        wr(4'd0, 32'd1);
        run(2000, 0, 0);
        chk("base_beats", 32'(beats), 32'd576);
        chk("base_drain", 32'(done_cyc - acc_cyc), 32'd4);
        chk("base_status", cfg_rdata, 32'h1);
        chk("b0_pad", 32'(at(0).pad), 32'd1);
        chk("b0_first", 32'(at(0).first), 32'd1);
        chk("b4_abuf", 32'(at(4).abuf), 32'd0);
        chk("b4_wbuf", 32'(at(4).wbuf), 32'd64);
        chk("b4_pad", 32'(at(4).pad), 32'd0);
        chk("b8_last", 32'(at(8).last), 32'd1);
        chk("b8_psum", 32'(at(8).psum), 32'd0);
        chk("b9_psum", 32'(at(9).psum), 32'd1);
        chk("b575_psum", 32'(at(575).psum), 32'd63);

        // tiling: COUT 40 -> three tiles, 1728 beats
        geometry(3, 3, 8, 8, 1, 1, 8, 8, 40);
        wr(4'd0, 32'd1);
        run(6000, 0, 0);
        chk("tile_beats", 32'(beats), 32'd1728);
        chk("t580_wbuf", 32'(at(580).wbuf), 32'd208);
        chk("t580_psum", 32'(at(580).psum), 32'd64);
        chk("t580_tile", 32'(at(580).tile), 32'd1);
        chk("t1727_tile", 32'(at(1727).tile), 32'd2);
        chk("t1727_psum", 32'(at(1727).psum), 32'd191);

        // stride 2, no pad, 4x4 out; stall 5 cycles on beat (oy1,ox2,ky2,kx1) = index 61
        geometry(3, 3, 9, 9, 2, 0, 4, 4, 16);
        wr(4'd0, 32'd1);
        run(1000, 61, 4);
        chk("str_beats", 32'(beats), 32'd144);
        chk("str_stable", 32'(stable), 32'd1);
        chk("s61_abuf", 32'(at(61).abuf), 32'd41);
        chk("s61_pad", 32'(at(61).pad), 32'd0);
        chk("s61_wbuf", 32'(at(61).wbuf), 32'd112);
        chk("s61_psum", 32'(at(61).psum), 32'd6);
        cfg_addr = 4'd8; #1;
`ifdef PE_SEQ_PERF_EN
        chk("perf_stall", cfg_rdata, 32'd5);
`else
        chk("perf_absent", cfg_rdata, 32'd0);
`endif
        cfg_addr = 4'd1; #1;

        // KW = 0 -> config error, no beats
        geometry(3, 0, 8, 8, 1, 1, 8, 8, 10);
        wr(4'd0, 32'd1);
        saw_valid = out_valid;
        step();
        saw_valid = saw_valid | out_valid;
        chk("cfgerr_status", cfg_rdata, 32'h9);
        chk("cfgerr_novalid", 32'(saw_valid), 32'd0);

        // start while running is ignored and flagged
        geometry(3, 3, 8, 8, 1, 1, 8, 8, 10);
        wr(4'd0, 32'd1);
        run(2000, 20, 1);
        chk("ign_beats", 32'(beats), 32'd576);
        chk("ign_status", cfg_rdata, 32'h5);

        // abort at beat 100
        wr(4'd0, 32'd1);
        run(2000, 100, 2);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_status", cfg_rdata, 32'h10);
        chk("abort_beats", 32'(beats), 32'd100);
        step();
        chk("abort_quiet", 32'(out_valid), 32'd0);

        // reset at beat 50, then a fresh full run
        wr(4'd0, 32'd1);
        run(2000, 50, 3);
        chk("mrst_ctl", 32'({out_valid, pad_zero, acc_first, acc_last, busy, tile_idx, psum_addr}), 32'd0);
        chk("mrst_addr", {wbuf_addr, abuf_addr}, 32'd0);
        chk("mrst_status", cfg_rdata, 32'd0);
        rst_n = 1'b1;
        step();
        geometry(3, 3, 8, 8, 1, 1, 8, 8, 10);
        wr(4'd0, 32'd1);
        run(2000, 0, 0);
        chk("fresh_beats", 32'(beats), 32'd576);
        chk("fresh_last", 32'(at(575).last), 32'd1);
        chk("fresh_status", cfg_rdata, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
